mem_wb_stage: RTL
=================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have EX/MEM-side inputs: jumpI, branchI, memReadI, memToRegI, memWriteI, regWriteI, zfI, each in 1.
REQ-003 SHALL have inputs siguienteInstruccionI  in  32  branch/jump target; aluResultI  in  32  ALU result / byte address; readData2I  in  32  store data; writeRegistrerI  in  5  destination register.
REQ-004 SHALL have outputs pcSrcO  out  1  take branch/jump target; targetO  out  32  target address.
REQ-005 SHALL have MEM/WB-side outputs regWriteO  out  1; memToRegO  out  1; readDataO  out  32  load data; aluResultO  out  32; writeRegistrerO  out  5.
REQ-006 SHALL have outputs loadCntO  out  16  load count; storeCntO  out  16  store count; misalignO  out  1  sticky misaligned-access flag.

Function
REQ-007 SHALL contain a 256 x 32 data memory indexed by aluResultI[9:2]; aluResultI[31:10] ignored (addresses wrap modulo 1 KiB).
REQ-008 SHALL drive pcSrcO = jumpI | (branchI & zfI) and targetO = siguienteInstruccionI combinationally, with zero latency.
REQ-009 SHALL write readData2I to mem[aluResultI[9:2]] on a rising clk edge when memWriteI=1 and the write is not suppressed (REQ-017).
REQ-010 SHALL register mem[aluResultI[9:2]] into readDataO on a rising edge when memReadI=1, and register 0 when memReadI=0.
REQ-011 SHALL return pre-write contents in readDataO when memReadI and memWriteI are both 1 on the same edge; the write still occurs.
REQ-012 SHALL let a load see data written by a store on any earlier edge.
REQ-013 SHALL register regWriteI, memToRegI, aluResultI and writeRegistrerI into the matching outputs on every rising edge, with latency exactly 1 cycle.
REQ-014 SHALL increment loadCntO on each edge with memReadI=1, and storeCntO on each edge with a performed write; both saturate at 16'hFFFF with no wrap.
REQ-015 SHALL not reset memory contents; they remain undefined until written.

Reset
REQ-016 SHALL, while rst=1, force readDataO, aluResultO, writeRegistrerO, regWriteO, memToRegO, loadCntO, storeCntO and misalignO to 0, independent of clk, and SHALL suppress memory writes.
REQ-017 SHALL, on rst asserting mid-operation, drop any write pending at the next edge; the first capture after rst deasserts uses the inputs present at that edge.

Configuration
REQ-018 SHALL, with macro MISALIGN_TRAP_EN defined, treat an access with aluResultI[1:0] != 0 and (memReadI | memWriteI) as misaligned: write suppressed, readDataO=0, regWriteO=0, storeCntO not incremented, misalignO set and held until rst.
REQ-019 SHALL, without MISALIGN_TRAP_EN, ignore aluResultI[1:0], tie misalignO to 0, and apply no suppression.

Verification
REQ-020 SHALL cover: store 32'hDEADBEEF to addr 0x10, load addr 0x10 next cycle -> readDataO=32'hDEADBEEF one cycle after the load; storeCntO=1, loadCntO=1.
REQ-021 SHALL cover: branchI=1, zfI=1, siguienteInstruccionI=0x40 -> pcSrcO=1, targetO=0x40 same cycle; branchI=1, zfI=0, jumpI=0 -> pcSrcO=0.
REQ-022 SHALL cover: memory holds 0x1 at addr 0x20; read and write 0x2 to addr 0x20 on the same edge -> readDataO=0x1; a subsequent load returns 0x2.
REQ-023 SHALL cover: store to 0x404 then load 0x004 -> load returns the stored value (wrap); 70000 loads -> loadCntO=16'hFFFF.
REQ-024 SHALL cover: with MISALIGN_TRAP_EN, store to 0x13 -> memory unchanged, misalignO=1 until rst; rst pulsed mid-store -> all outputs 0 immediately and no write occurs.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// Bundle between the EX/MEM side, the data memory stage and MEM/WB.
// master: drives the *I signals; slave (mem_wb_stage): drives the *O signals.
interface mem_wb_stage_if;
  logic        jumpI;
  logic        branchI;
  logic        memReadI;
  logic        memToRegI;
  logic        memWriteI;
  logic        regWriteI;
  logic        zfI;
  logic [31:0] siguienteInstruccionI;
  logic [31:0] aluResultI;
  logic [31:0] readData2I;
  logic [4:0]  writeRegistrerI;

  logic        pcSrcO;
  logic [31:0] targetO;
  logic        regWriteO;
  logic        memToRegO;
  logic [31:0] readDataO;
  logic [31:0] aluResultO;
  logic [4:0]  writeRegistrerO;
  logic [15:0] loadCntO;
  logic [15:0] storeCntO;
  logic        misalignO;

  modport master (
    output jumpI, branchI, memReadI, memToRegI,
    output memWriteI, regWriteI, zfI,
    output siguienteInstruccionI, aluResultI,
    output readData2I, writeRegistrerI,
    input  pcSrcO, targetO, regWriteO, memToRegO,
    input  readDataO, aluResultO, writeRegistrerO,
    input  loadCntO, storeCntO, misalignO
  );

  modport slave (
    input  jumpI, branchI, memReadI, memToRegI,
    input  memWriteI, regWriteI, zfI,
    input  siguienteInstruccionI, aluResultI,
    input  readData2I, writeRegistrerI,
    output pcSrcO, targetO, regWriteO, memToRegO,
    output readDataO, aluResultO, writeRegistrerO,
    output loadCntO, storeCntO, misalignO
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM stage + MEM/WB register: 256x32 data RAM, branch resolve, load/store counters.
// Ports: clk, rst (async active-high), bus (mem_wb_stage_if.slave).
// Option: define MISALIGN_TRAP_EN to trap accesses with aluResultI[1:0] != 0.
module mem_wb_stage (
  input  logic           clk,
  input  logic           rst,
  mem_wb_stage_if.slave  bus
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [31:0] mem [256];
  logic [7:0]  idx;
  logic        mis;
  logic        we;

  logic [31:0] rd_d,  rd_q;
  logic [31:0] alu_d, alu_q;
  logic [4:0]  wr_d,  wr_q;
  logic        rw_d,  rw_q;
  logic        m2r_d, m2r_q;
  logic [15:0] lc_d,  lc_q;
  logic [15:0] sc_d,  sc_q;
  logic        mis_d, mis_q;

  // Word index; upper bits ignored so addresses wrap every 1 KiB.
  assign idx = bus.aluResultI[9:2];

`ifdef MISALIGN_TRAP_EN
  assign mis = (bus.aluResultI[1:0] != 2'b00) &
               (bus.memReadI | bus.memWriteI);
`else
  assign mis = 1'b0;
`endif

  // rst gates the write so a store in flight when reset hits is dropped.
  assign we = bus.memWriteI & ~mis & ~rst;

  assign bus.pcSrcO  = bus.jumpI | (bus.branchI & bus.zfI);
  assign bus.targetO = bus.siguienteInstruccionI;

  // Memory is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= bus.readData2I;
    end
  end

  always_comb begin
    rd_d  = 32'h0;
    alu_d = bus.aluResultI;
    wr_d  = bus.writeRegistrerI;
    rw_d  = bus.regWriteI & ~mis;
    m2r_d = bus.memToRegI;
    lc_d  = lc_q;
    sc_d  = sc_q;
    mis_d = mis_q | mis;
    // Old contents are read here, giving read-before-write on a shared edge.
    if (bus.memReadI && !mis) begin
      rd_d = mem[idx];
    end
    if (bus.memReadI && lc_q != CNT_MAX) begin
      lc_d = lc_q + 16'd1;
    end
    if (bus.memWriteI && !mis && sc_q != CNT_MAX) begin
      sc_d = sc_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= 32'h0;
      alu_q <= 32'h0;
      wr_q  <= 5'h0;
      rw_q  <= 1'b0;
      m2r_q <= 1'b0;
      lc_q  <= 16'h0;
      sc_q  <= 16'h0;
      mis_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      alu_q <= alu_d;
      wr_q  <= wr_d;
      rw_q  <= rw_d;
      m2r_q <= m2r_d;
      lc_q  <= lc_d;
      sc_q  <= sc_d;
      mis_q <= mis_d;
    end
  end

  assign bus.readDataO       = rd_q;
  assign bus.aluResultO      = alu_q;
  assign bus.writeRegistrerO = wr_q;
  assign bus.regWriteO       = rw_q;
  assign bus.memToRegO       = m2r_q;
  assign bus.loadCntO        = lc_q;
  assign bus.storeCntO       = sc_q;
  assign bus.misalignO       = mis_q;

endmodule
